// File: rtl/niu32_mmio_if.sv
// Bus interface between the Niu32 memory stage (master) and the MMIO block (slave).
// Carries the MAR address, store data, the WrMem/DrMem strobes and the
// combinational hit/read-data return path.
interface niu32_mmio_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] rdata;
    logic                 we;
    logic                 re;
    logic                 hit;

    modport master (
        output addr, wdata, we, re,
        input  hit, rdata
    );

    modport slave (
        input  addr, wdata, we, re,
        output hit, rdata
    );
endinterface

// File: rtl/niu32_mmio.sv
// Niu32 memory-mapped I/O controller.
// Claims six full-word addresses in the 0xFFFF0000 I/O window, owns the HEX/LEDR/LEDG
// output registers, synchronises KEY/SWITCH and keeps sticky key-press flags.
// Optional build macro: NIU32_KEY_DEBOUNCE_EN adds a per-key stability counter
// after the key synchroniser (DEBOUNCE_CYCLES consecutive differing cycles).
module niu32_mmio #(
    parameter int                   WORD_SIZE       = 32,
    parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
    parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
    parameter logic [WORD_SIZE-1:0] ADDR_KEYEDGE    = 32'hFFFF0104,
    parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120,
    parameter logic [15:0]          DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic               clk,
    input  logic               reset_n,
    niu32_mmio_if.slave        bus,
    input  logic [3:0]         KEY,
    input  logic [9:0]         SWITCH,
    output logic [9:0]         LEDR,
    output logic [7:0]         LEDG,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3
);

    logic        sel_hex, sel_ledr, sel_ledg, sel_key, sel_keyedge, sel_switch;
    logic [15:0] hex_reg;
    logic [9:0]  ledr_reg;
    logic [7:0]  ledg_reg;
    logic [3:0]  keyedge;
    logic [3:0]  edge_clr;
    logic [3:0]  key_s1, key_s2;
    logic [9:0]  sw_s1, sw_s2;
    logic [3:0]  key_level;
    logic [3:0]  key_level_d;
    logic        unused_wdata;

    assign unused_wdata = ^bus.wdata[WORD_SIZE-1:16];

    // Seven-segment decode, active-low, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Exact full-word address decode; hit is purely combinational.
    always_comb begin
        sel_hex     = (bus.addr == ADDR_HEX);
        sel_ledr    = (bus.addr == ADDR_LEDR);
        sel_ledg    = (bus.addr == ADDR_LEDG);
        sel_key     = (bus.addr == ADDR_KEY);
        sel_keyedge = (bus.addr == ADDR_KEYEDGE);
        sel_switch  = (bus.addr == ADDR_SWITCH);
    end

    assign bus.hit = sel_hex | sel_ledr | sel_ledg | sel_key | sel_keyedge | sel_switch;

    // Output register writes; pins follow on the same edge that samples we.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
        end else if (bus.we) begin
            if (sel_hex)  hex_reg  <= bus.wdata[15:0];
            if (sel_ledr) ledr_reg <= bus.wdata[9:0];
            if (sel_ledg) ledg_reg <= bus.wdata[7:0];
        end
    end

    // Two-flop synchronisers; reset to keys released (high) and switches off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SWITCH;
            sw_s2  <= sw_s1;
        end
    end

`ifdef NIU32_KEY_DEBOUNCE_EN
    logic [3:0]       key_sync;
    logic [3:0]       key_db, key_db_d;
    logic [3:0][15:0] db_cnt, db_cnt_d;

    assign key_sync = ~key_s2;

    // Per-key stability counter: the debounced level flips only after the
    // synchronised level has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        key_db_d = key_db;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (key_sync[i] != key_db[i]) begin
                if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    key_db_d[i] = key_sync[i];
                end else begin
                    db_cnt_d[i] = db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Debounce state; reset discards any partially counted transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_db <= '0;
            db_cnt <= '0;
        end else begin
            key_db <= key_db_d;
            db_cnt <= db_cnt_d;
        end
    end

    assign key_level   = key_db;
    assign key_level_d = key_db_d;
`else
    logic [15:0] unused_debounce;

    assign unused_debounce = DEBOUNCE_CYCLES;
    assign key_level       = ~key_s2;
    assign key_level_d     = ~key_s1;
`endif

    assign edge_clr = (bus.we && sel_keyedge) ? bus.wdata[3:0] : 4'h0;

    // Sticky press flags: rising key level sets, write-1 clears, set wins a tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyedge <= '0;
        end else begin
            keyedge <= (keyedge & ~edge_clr) | (key_level_d & ~key_level);
        end
    end

    // Combinational read mux, zero-extended, zero unless re on a mapped address.
    always_comb begin
        bus.rdata = '0;
        if (bus.re) begin
            if (sel_hex)     bus.rdata[15:0] = hex_reg;
            if (sel_ledr)    bus.rdata[9:0]  = ledr_reg;
            if (sel_ledg)    bus.rdata[7:0]  = ledg_reg;
            if (sel_key)     bus.rdata[3:0]  = key_level;
            if (sel_keyedge) bus.rdata[3:0]  = keyedge;
            if (sel_switch)  bus.rdata[9:0]  = sw_s2;
        end
    end

    assign LEDR = ledr_reg;
    assign LEDG = ledg_reg;
    assign HEX0 = seg7(hex_reg[3:0]);
    assign HEX1 = seg7(hex_reg[7:4]);
    assign HEX2 = seg7(hex_reg[11:8]);
    assign HEX3 = seg7(hex_reg[15:12]);

endmodule
